ro_puf_ctrl: RTL and testbench

Sequencing controller for the ring-oscillator PUF array. On `start` it walks through `N_BITS` oscillator pairs. For each pair it:
- enables the selected pair with the latched configuration word;
- counts rising edges of both oscillator outputs over a fixed window of `clk` cycles;
- compares the counts and stores one response bit.

It sits between the RO array (with its external pair mux) and the system bus or host logic that issues challenges and reads responses.

---
 rtl/ro_puf_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ro_puf_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF sequencing controller.
// For each RO pair: settle, count rising edges of both oscillators over a fixed
// window, drain the synchronizer pipeline, then compare the counts into one
// response bit.
module ro_puf_ctrl #(
  parameter int unsigned N_BITS     = 8,
  parameter int unsigned WIN_CYCLES = 1024,
  parameter int unsigned SETTLE     = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [3:0]                challenge,
  input  logic                      ro_a,
  input  logic                      ro_b,
  output logic                      ro_en,
  output logic [3:0]                ro_cfg,
  output logic [$clog2(N_BITS)-1:0] pair_sel,
  output logic                      busy,
  output logic                      done,
  output logic [N_BITS-1:0]         response,
  output logic                      tie
);

  localparam int unsigned SelW   = $clog2(N_BITS);
  localparam int unsigned TmrMax = (WIN_CYCLES > SETTLE) ? WIN_CYCLES : SETTLE;
  // Wide enough for the longest phase and for the 3-cycle drain.
  localparam int unsigned TmrW   = $clog2(TmrMax + 3);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCount,
    StDrain,
    StCompare,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [3:0]        cfg_q, cfg_d;
  logic [N_BITS-1:0] resp_q, resp_d;
  logic              tie_q, tie_d;

  logic [2:0]        a_sync_q, b_sync_q;
  logic [CNT_W-1:0]  cnt_a_q, cnt_b_q;
  logic              edge_a, edge_b, cnt_en;

  // Two synchronizer flops plus one edge-detect flop per oscillator input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[1:0], ro_a};
      b_sync_q <= {b_sync_q[1:0], ro_b};
    end
  end

  // The detect flop always tracks the synchronized level, so no false edge
  // appears on the first counting cycle.
  assign edge_a = a_sync_q[1] & ~a_sync_q[2];
  assign edge_b = b_sync_q[1] & ~b_sync_q[2];
  // Drain keeps counting so edges still in the synchronizers are not lost.
  assign cnt_en = (state_q == StCount) || (state_q == StDrain);

  // Saturating edge counters, cleared while the pair settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if (state_q == StSettle) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if (cnt_en) begin
      if (edge_a && (cnt_a_q != '1)) cnt_a_q <= cnt_a_q + 1'b1;
      if (edge_b && (cnt_b_q != '1)) cnt_b_q <= cnt_b_q + 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      sel_q   <= '0;
      cfg_q   <= '0;
      resp_q  <= '0;
      tie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      sel_q   <= sel_d;
      cfg_q   <= cfg_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
    end
  end

  // Next-state logic: per-pair settle/count/drain/compare sequence.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    sel_d   = sel_q;
    cfg_d   = cfg_q;
    resp_d  = resp_q;
    tie_d   = tie_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cfg_d   = challenge;
          sel_d   = '0;
          resp_d  = '0;
          tie_d   = 1'b0;
          tmr_d   = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (tmr_q == TmrW'(SETTLE - 1)) begin
          tmr_d   = '0;
          state_d = StCount;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StCount: begin
        if (tmr_q == TmrW'(WIN_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = StDrain;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StDrain: begin
        if (tmr_q == TmrW'(2)) begin
          tmr_d   = '0;
          state_d = StCompare;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StCompare: begin
        resp_d[sel_q] = (cnt_a_q > cnt_b_q);
        if (cnt_a_q == cnt_b_q) tie_d = 1'b1;
        if (sel_q == SelW'(N_BITS - 1)) begin
          state_d = StDone;
        end else begin
          // Pair index only moves while the enable is low.
          sel_d   = sel_q + 1'b1;
          state_d = StSettle;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ro_en    = (state_q == StSettle) || (state_q == StCount);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign ro_cfg   = cfg_q;
  assign pair_sel = sel_q;
  assign response = resp_q;
  assign tie      = tie_q;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Directed bench for ro_puf_ctrl: response patterns, ties, start filtering,
// mid-run reset, pair-boundary timing and counter saturation.
module tb_ro_puf_ctrl;

  localparam int unsigned NB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    challenge = 4'h0;
  logic          ro_a = 1'b0;
  logic          ro_b_gen = 1'b0;
  logic          ro_b;
  logic          ro_en;
  logic [3:0]    ro_cfg;
  logic [1:0]    pair_sel;
  logic          busy, done, tie;
  logic [NB-1:0] response;

  // Second instance for the saturation case.
  logic          start2 = 1'b0;
  logic          ro_a2 = 1'b0;
  logic          ro_b2 = 1'b0;
  logic          ro_en2, busy2, done2, tie2;
  logic [3:0]    ro_cfg2;
  logic [0:0]    pair_sel2;
  logic [1:0]    response2;

  int mode = 0;  // 0: A fast on even pairs; 1: A fast everywhere, B == A on pair 2

  int n_checks = 0;
  int n_pass = 0;

  // Run statistics gathered by watch_run.
  int done_cyc, done_cnt, busy_first, busy_last, gaps, bad_gaps, steps, bad_steps, cfg_bad;
  logic [NB-1:0] resp_at_done;
  logic          tie_at_done;

  ro_puf_ctrl #(.N_BITS(4), .WIN_CYCLES(16), .SETTLE(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
    .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en), .ro_cfg(ro_cfg),
    .pair_sel(pair_sel), .busy(busy), .done(done), .response(response), .tie(tie)
  );

  ro_puf_ctrl #(.N_BITS(2), .WIN_CYCLES(512), .SETTLE(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .challenge(4'h7),
    .ro_a(ro_a2), .ro_b(ro_b2), .ro_en(ro_en2), .ro_cfg(ro_cfg2),
    .pair_sel(pair_sel2), .busy(busy2), .done(done2), .response(response2), .tie(tie2)
  );

  always #5 clk = ~clk;  // posedges at 5 + 10k

  function automatic int half_a(input logic [1:0] s);
    if (mode == 0) return s[0] ? 50 : 20;
    return 20;
  endfunction

  function automatic int half_b(input logic [1:0] s);
    if (mode == 0) return s[0] ? 20 : 50;
    return 50;
  endfunction

  // Oscillator models: period depends on the selected pair, held low when disabled.
  initial begin
    #2;
    forever begin
      #(half_a(pair_sel));
      ro_a = ro_en ? ~ro_a : 1'b0;
    end
  end

  initial begin
    #8;
    forever begin
      #(half_b(pair_sel));
      ro_b_gen = ro_en ? ~ro_b_gen : 1'b0;
    end
  end

  assign ro_b = (mode == 1 && pair_sel == 2'd2) ? ro_a : ro_b_gen;

  // Saturation stimulus: A rises every 2 clocks, B every 4 clocks.
  initial begin
    #3;
    forever #10 ro_a2 = ~ro_a2;
  end

  initial begin
    #3;
    forever #20 ro_b2 = ~ro_b2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive start so that it is sampled at the next posedge (cycle 0).
  task automatic issue_start(input logic [3:0] ch);
    @(negedge clk);
    challenge = ch;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Observe cycles 1..ncyc at negedges; optionally inject ignored starts and a
  // challenge change mid-run.
  task automatic watch_run(input int ncyc, input bit inject, input logic [3:0] cfg_exp);
    int   low_run;
    logic prev_en;
    logic [1:0] prev_sel;
    done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1;
    gaps = 0; bad_gaps = 0; steps = 0; bad_steps = 0; cfg_bad = 0;
    low_run = 0; prev_en = 1'b1; prev_sel = 2'd0;
    resp_at_done = '0; tie_at_done = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          resp_at_done = response;
          tie_at_done = tie;
        end
      end
      if (busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (ro_cfg !== cfg_exp) cfg_bad++;
      if (c > 1 && pair_sel !== prev_sel) begin
        steps++;
        if (prev_en !== 1'b0 || pair_sel !== prev_sel + 2'd1) bad_steps++;
      end
      if (!ro_en) begin
        low_run++;
      end else begin
        if (low_run > 0 && c > 1) begin
          gaps++;
          if (low_run != 4) bad_gaps++;
        end
        low_run = 0;
      end
      prev_en = ro_en;
      prev_sel = pair_sel;
      if (inject) begin
        start = (c == 5 || c == 89);
        if (c == 10) challenge = ~cfg_exp;
      end
    end
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && !done; k++) @(negedge clk);
    check("done_within_budget", done, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ro_en", ro_en, 1'b0);
    check("rst_ro_cfg", ro_cfg, 4'h0);
    check("rst_pair_sel", pair_sel, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_response", response, 4'h0);
    check("rst_tie", tie, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Alternating pairs: A faster on pairs 0 and 2.
    mode = 0;
    issue_start(4'hA);
    watch_run(90, 1'b0, 4'hA);
    check("t1_done_cyc", done_cyc, 89);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_busy_first", busy_first, 1);
    check("t1_busy_last", busy_last, 89);
    check("t1_gaps", gaps, 3);
    check("t1_bad_gaps", bad_gaps, 0);
    check("t1_steps", steps, 3);
    check("t1_bad_steps", bad_steps, 0);
    check("t1_cfg_bad", cfg_bad, 0);
    check("t1_resp_at_done", resp_at_done, 4'b0101);
    check("t1_tie_at_done", tie_at_done, 1'b0);
    check("t1_resp_hold", response, 4'b0101);
    check("t1_cfg_hold", ro_cfg, 4'hA);

    // Identical oscillators on pair 2 give a tie and a zero bit.
    mode = 1;
    issue_start(4'h3);
    watch_run(90, 1'b0, 4'h3);
    check("t2_done_cyc", done_cyc, 89);
    check("t2_resp", resp_at_done, 4'b1011);
    check("t2_tie", tie_at_done, 1'b1);
    check("t2_tie_hold", tie, 1'b1);

    // Starts during the run and on the done cycle are ignored; challenge
    // changes mid-run do not reach ro_cfg.
    mode = 0;
    issue_start(4'h5);
    watch_run(90, 1'b1, 4'h5);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_done_cyc", done_cyc, 89);
    check("t3_busy_last", busy_last, 89);
    check("t3_cfg_bad", cfg_bad, 0);
    check("t3_resp", resp_at_done, 4'b0101);
    // Now at cycle 90: this start must be accepted.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("t3_restart_busy", busy, 1'b1);
    check("t3_restart_cfg", ro_cfg, 4'hA);
    check("t3_restart_sel", pair_sel, 2'd0);
    wait_done(150);
    check("t3_restart_resp", response, 4'b0101);
    @(negedge clk);

    // Asynchronous reset in the middle of pair 1's counting window.
    issue_start(4'h6);
    repeat (30) @(negedge clk);
    check("t4_pre_sel", pair_sel, 2'd1);
    check("t4_pre_en", ro_en, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_ro_en", ro_en, 1'b0);
    check("t4_rst_ro_cfg", ro_cfg, 4'h0);
    check("t4_rst_sel", pair_sel, 2'd0);
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_done", done, 1'b0);
    check("t4_rst_resp", response, 4'h0);
    check("t4_rst_tie", tie, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_idle_busy", busy, 1'b0);
    check("t4_idle_en", ro_en, 1'b0);
    issue_start(4'h9);
    wait_done(150);
    check("t4_resp", response, 4'b0101);
    check("t4_tie", tie, 1'b0);
    check("t4_cfg", ro_cfg, 4'h9);
    @(negedge clk);

    // Saturation: A produces more than 255 edges in the window.
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int k = 0; k < 1200 && !done2; k++) @(negedge clk);
    check("t5_done_within_budget", done2, 1'b1);
    check("t5_cnt_a_sat", dut2.cnt_a_q, 8'd255);
    check("t5_resp", response2, 2'b11);
    check("t5_tie", tie2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
